ex_muldiv_unit: RTL and testbench

EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

---
 rtl/ex_muldiv_unit.sv | 148 ++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit for the EX stage: WIDTH-cycle shift-add multiply
// and restoring divide, with HI/LO result registers and MTHI/MTLO writes.
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             mthi,
  input  logic             mtlo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;

  // Operation context captured on the start edge
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             div_zero;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] m;

  logic             start_go;
  logic             last_iter;
  logic             op_signed;
  logic signed [WIDTH-1:0] rs_s;
  logic signed [WIDTH-1:0] rt_s;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_r;
  logic [WIDTH:0]     div_diff;
  logic [WIDTH-1:0]   acc_n;
  logic [WIDTH-1:0]   q_n;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic sgn);
    magnitude = (sgn && (v < 0)) ? WIDTH'(-v) : WIDTH'(v);
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic en);
    cond_neg = en ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v,
                                                   input logic en);
    cond_neg2 = en ? (~v + (2*WIDTH)'(1)) : v;
  endfunction

  assign rs_s      = rs_data;
  assign rt_s      = rt_data;
  assign op_signed = op[0];
  assign start_go  = (state == IDLE) && start;
  assign last_iter = (state == RUN) && (cnt == LAST);
  assign busy      = (state == RUN);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One iteration: shift-add for multiply, restoring subtract for divide
  always_comb begin
    mul_sum  = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
    div_r    = {acc, q[WIDTH-1]};
    div_diff = div_r - {1'b0, m};
    if (is_div) begin
      acc_n = div_diff[WIDTH] ? div_r[WIDTH-1:0] : div_diff[WIDTH-1:0];
      q_n   = {q[WIDTH-2:0], ~div_diff[WIDTH]};
    end else begin
      acc_n = mul_sum[WIDTH:1];
      q_n   = {mul_sum[0], q[WIDTH-1:1]};
    end
  end

  // Sign correction applied to the outcome of the final iteration
  always_comb begin
    prod = cond_neg2({acc_n, q_n}, neg_q);
    if (is_div) begin
      res_lo = div_zero ? '1 : cond_neg(q_n, neg_q);
      res_hi = cond_neg(acc_n, neg_r);
    end else begin
      res_lo = prod[WIDTH-1:0];
      res_hi = prod[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_nxt;
      done  <= last_iter;
      if (start_go)
        cnt <= '0;
      else if (state == RUN)
        cnt <= cnt + CNT_W'(1);
      if (last_iter) begin
        hi <= res_hi;
        lo <= res_lo;
      end else if (state == IDLE && !start) begin
        if (mthi) hi <= rs_data;
        if (mtlo) lo <= rs_data;
      end
    end
  end

  // Datapath registers carry no reset; they are fully loaded on every start
  always_ff @(posedge clock) begin
    if (start_go) begin
      is_div   <= op[1];
      acc      <= '0;
      q        <= magnitude(rs_s, op_signed);
      m        <= magnitude(rt_s, op_signed);
      neg_q    <= op_signed && ((rs_s < 0) != (rt_s < 0));
      neg_r    <= op_signed && (rs_s < 0);
      div_zero <= op[1] && (rt_data == '0);
    end else if (state == RUN) begin
      acc <= acc_n;
      q   <= q_n;
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed-vector bench for ex_muldiv_unit with hand-computed results.
module tb_ex_muldiv_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        mthi;
  logic        mtlo;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [1:0] MULTU = 2'b00, MULT = 2'b01, DIVU = 2'b10, DIV = 2'b11;

  ex_muldiv_unit #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .mthi(mthi), .mtlo(mtlo),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  // Issue one operation; optionally inject start+mthi+mtlo with other
  // operands while sampling busy cycle number inj (0 = no injection).
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_hi,
                       input logic [31:0] exp_lo, input int inj);
    int nbusy;
    int ndone;
    @(negedge clock);
    op = o; rs_data = a; rt_data = b; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    nbusy = 0;
    ndone = 0;
    while (busy && nbusy < 100) begin
      nbusy++;
      if (nbusy == inj) begin
        start = 1'b1; mthi = 1'b1; mtlo = 1'b1;
        op = DIVU; rs_data = 32'hDEADBEEF; rt_data = 32'd3;
      end else begin
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      end
      @(posedge clock); #1;
      if (done) ndone++;
    end
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    chk({tag, "_busy_cycles"}, 32'(nbusy), 32'd32);
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
    @(posedge clock); #1;
    if (done) ndone++;
    chk({tag, "_done_pulses"}, 32'(ndone), 32'd1);
    chk({tag, "_idle_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int ndone;
    int nbusy;
    reset = 1'b1; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
    mthi = 1'b0; mtlo = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    reset = 1'b0;

    do_op("multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0);
    do_op("mult_neg",  MULT,  32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 0);
    do_op("div_neg",   DIV,   32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    do_op("div_negb",  DIV,   32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 0);
    do_op("divu_zero", DIVU,  32'd7, 32'd0, 32'h00000007, 32'hFFFFFFFF, 0);
    do_op("div_zero",  DIV,   32'hFFFFFFF8, 32'd0, 32'hFFFFFFF8, 32'hFFFFFFFF, 0);
    do_op("div_ovf",   DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0);
    do_op("divu_100",  DIVU,  32'd100, 32'd7, 32'd2, 32'd14, 0);
    do_op("multu_16",  MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 0);
    do_op("inj_run",   MULT,  32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 5);
    do_op("inj_done",  MULTU, 32'd6, 32'd7, 32'h0, 32'd42, 32);

    // MTLO alone, then MTHI and MTLO together
    @(negedge clock);
    mtlo = 1'b1; rs_data = 32'h12345678;
    @(posedge clock); #1;
    mtlo = 1'b0;
    chk("mtlo_lo", lo, 32'h12345678);
    chk("mtlo_hi", hi, 32'h0);
    @(negedge clock);
    mthi = 1'b1; mtlo = 1'b1; rs_data = 32'hCAFEF00D;
    @(posedge clock); #1;
    mthi = 1'b0; mtlo = 1'b0;
    chk("mtboth_hi", hi, 32'hCAFEF00D);
    chk("mtboth_lo", lo, 32'hCAFEF00D);

    // start with mthi on the same edge: start wins
    @(negedge clock);
    start = 1'b1; mthi = 1'b1; op = MULTU; rs_data = 32'd3; rt_data = 32'd4;
    @(posedge clock); #1;
    start = 1'b0; mthi = 1'b0;
    chk("startmthi_hi", hi, 32'hCAFEF00D);
    chk("startmthi_busy", 32'(busy), 32'd1);
    nbusy = 1;
    while (busy && nbusy < 100) begin
      @(posedge clock); #1;
      if (busy) nbusy++;
    end
    chk("startmthi_cycles", 32'(nbusy), 32'd32);
    chk("startmthi_res_hi", hi, 32'h0);
    chk("startmthi_res_lo", lo, 32'd12);

    // Reset in the middle of a run aborts without a result
    @(negedge clock);
    start = 1'b1; op = MULTU; rs_data = 32'd9; rt_data = 32'd9;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    chk("abort_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hi", hi, 32'h0);
    chk("abort_lo", lo, 32'h0);
    ndone = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    chk("abort_lo_after", lo, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
